board_store: RTL and testbench

//  Occupancy memory for the 10x20 Tetris playfield: the responder side of the board read/write

---
 rtl/board_store.sv | 176 +++++++++++++++++
 tb/tb_board_store.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_store.sv
// rtl/board_store.sv - Tetris playfield occupancy memory with line-clear engine
//
// Purpose:
//   Holds one occupancy bit per cell of a COLS x ROWS playfield. It answers
//   combinational reads, accepts single-cycle cell writes while idle, and runs
//   a scan/collapse/count line-clear pass when the game FSM requests one.
//
// Optional feature macro: BOARD_VGA_PORT_EN
//   When defined, adds a second combinational read port (vga_rx, vga_ry ->
//   vga_rdata) for the renderer. It reads the live contents and is
//   independent of the clear engine.
//
// Ports:
//   CLOCK_50       in   1  system clock, rising edge
//   resetn         in   1  asynchronous reset, active-low
//   board_rx/ry    in 4/5  game read address
//   board_rdata    out  1  occupancy of (board_rx, board_ry); OOB_RDATA outside board
//   board_we       in   1  cell write strobe (honoured only while idle)
//   board_wx/wy    in 4/5  write address; out-of-range writes are dropped
//   board_wdata    in   1  1 = occupied, 0 = free
//   clear_start    in   1  pulse: scan the board and remove full rows
//   clear_busy     out  1  engine active (SCAN, SHIFT, DONE)
//   clear_done     out  1  one-cycle pulse when the engine finishes
//   lines_cleared  out  3  full rows removed by the last clear, saturates at 7
//   vga_rx/ry      in 4/5  renderer read address      (BOARD_VGA_PORT_EN only)
//   vga_rdata      out  1  renderer read data         (BOARD_VGA_PORT_EN only)

module board_store #(
    parameter int   COLS      = 10,
    parameter int   ROWS      = 20,
    parameter logic OOB_RDATA = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] board_rx,
    input  logic [4:0] board_ry,
    output logic       board_rdata,
    input  logic       board_we,
    input  logic [3:0] board_wx,
    input  logic [4:0] board_wy,
    input  logic       board_wdata,
    input  logic       clear_start,
    output logic       clear_busy,
    output logic       clear_done,
    output logic [2:0] lines_cleared
`ifdef BOARD_VGA_PORT_EN
    ,
    input  logic [3:0] vga_rx,
    input  logic [4:0] vga_ry,
    output logic [0:0] vga_rdata
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [COLS-1:0]   r_cells [ROWS];
    logic [4:0]        r_row;
    logic [4:0]        r_k;
    logic [2:0]        r_lines;

    logic              w_row_full;
    logic              w_rd_in;
    logic              w_wr_in;

    // r_row always stays within 0..ROWS-1, so this index is always valid.
    assign w_row_full = &r_cells[r_row];

    assign w_rd_in = (board_rx < 4'(COLS)) && (board_ry < 5'(ROWS));
    assign w_wr_in = (board_wx < 4'(COLS)) && (board_wy < 5'(ROWS));

    assign board_rdata   = w_rd_in ? r_cells[board_ry][board_rx] : OOB_RDATA;
    assign clear_busy    = (r_state != S_IDLE);
    assign clear_done    = (r_state == S_DONE);
    assign lines_cleared = r_lines;

`ifdef BOARD_VGA_PORT_EN
    logic w_vga_in;
    assign w_vga_in     = (vga_rx < 4'(COLS)) && (vga_ry < 5'(ROWS));
    assign vga_rdata[0] = w_vga_in ? r_cells[vga_ry][vga_rx] : OOB_RDATA;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear_start) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_row_full) begin
                    w_next = S_SHIFT;
                end else if (r_row == 5'd0) begin
                    w_next = S_DONE;
                end
            end
            S_SHIFT: begin
                // k==1 is the last copy step; k==0 only happens when the
                // full row was row 0 and needs a single clearing cycle.
                if (r_k <= 5'd1) begin
                    w_next = S_SCAN;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < ROWS; r++) begin
                r_cells[r] <= '0;
            end
            r_row   <= '0;
            r_k     <= '0;
            r_lines <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A write coinciding with clear_start still lands, so the
                    // scan that follows sees it.
                    if (board_we && w_wr_in) begin
                        r_cells[board_wy][board_wx] <= board_wdata;
                    end
                    if (clear_start) begin
                        r_row   <= 5'(ROWS - 1);
                        r_lines <= 3'd0;
                    end
                end
                S_SCAN: begin
                    if (w_row_full) begin
                        r_k     <= r_row;
                        r_lines <= (r_lines == 3'd7) ? 3'd7 : r_lines + 3'd1;
                    end else if (r_row != 5'd0) begin
                        r_row <= r_row - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // r_row is left untouched so the collapsed row is rescanned.
                    if (r_k == 5'd0) begin
                        r_cells[0] <= '0;
                    end else begin
                        r_cells[r_k] <= r_cells[r_k - 5'd1];
                        if (r_k == 5'd1) begin
                            r_cells[0] <= '0;
                        end else begin
                            r_k <= r_k - 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_store.sv
// tb/tb_board_store.sv - self-checking bench for board_store
module tb_board_store;

    logic       clk;
    logic       resetn;
    logic [3:0] board_rx;
    logic [4:0] board_ry;
    logic       board_rdata;
    logic       board_we;
    logic [3:0] board_wx;
    logic [4:0] board_wy;
    logic       board_wdata;
    logic       clear_start;
    logic       clear_busy;
    logic       clear_done;
    logic [2:0] lines_cleared;
`ifdef BOARD_VGA_PORT_EN
    logic [3:0] vga_rx;
    logic [4:0] vga_ry;
    logic [0:0] vga_rdata;
`endif

    int checks = 0;
    int errors = 0;

    bit [9:0] m [20];

    board_store dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .board_rx     (board_rx),
        .board_ry     (board_ry),
        .board_rdata  (board_rdata),
        .board_we     (board_we),
        .board_wx     (board_wx),
        .board_wy     (board_wy),
        .board_wdata  (board_wdata),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .lines_cleared(lines_cleared)
`ifdef BOARD_VGA_PORT_EN
        ,
        .vga_rx       (vga_rx),
        .vga_ry       (vga_ry),
        .vga_rdata    (vga_rdata)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       we;
        logic [3:0] wx;
        logic [4:0] wy;
        logic       wd;
        logic [3:0] rx;
        logic [4:0] ry;
        logic       e_now;
        logic       e_next;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int r = 0; r < 20; r++) m[r] = '0;
    endtask

    task automatic model_write(input int x, input int y, input bit d);
        if (x < 10 && y < 20) m[y][x] = d;
    endtask

    // Full rows vanish, rows above drop down, empty rows enter at the top.
    // The scan pointer only moves up on a non-full row, so a full row is
    // removed at the pointer position it is met at.
    task automatic model_clear(output int lines, output int cyc);
        bit [9:0] n [20];
        int ptr;
        int cnt;
        int cost;
        for (int r = 0; r < 20; r++) n[r] = '0;
        ptr = 19; cnt = 0; cost = 0;
        for (int j = 19; j >= 0; j--) begin
            if (m[j] == 10'h3FF) begin
                cnt++;
                cost += ((ptr > 1) ? ptr : 1) + 1;
            end else begin
                n[ptr] = m[j];
                ptr--;
            end
        end
        for (int r = 0; r < 20; r++) m[r] = n[r];
        lines = (cnt > 7) ? 7 : cnt;
        cyc   = 21 + cost;
    endtask

    task automatic read_cell(input int x, input int y, output logic v);
        board_rx = 4'(x);
        board_ry = 5'(y);
`ifdef BOARD_VGA_PORT_EN
        vga_rx = 4'(x);
        vga_ry = 5'(y);
`endif
        #1;
        v = board_rdata;
`ifdef BOARD_VGA_PORT_EN
        check("vga_vs_game", int'(vga_rdata[0]), int'(board_rdata));
`endif
    endtask

    task automatic check_board(input string name);
        logic v;
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < 10; x++) begin
                read_cell(x, y, v);
                if (v !== m[y][x]) begin
                    $display("FAIL %s cell(%0d,%0d): got %b expected %b", name, x, y, v, m[y][x]);
                    errors++;
                end
                checks++;
            end
        end
        read_cell(10, 0, v);
        check({name, "_oob_x"}, int'(v), 1);
        read_cell(0, 20, v);
        check({name, "_oob_y"}, int'(v), 1);
    endtask

    task automatic wr(input int x, input int y, input bit d);
        board_we    = 1'b1;
        board_wx    = 4'(x);
        board_wy    = 5'(y);
        board_wdata = d;
        @(posedge clk); #1;
        board_we = 1'b0;
        model_write(x, y, d);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_zero();
        @(posedge clk); #1;
    endtask

    task automatic do_clear(input string name, input bit noise);
        int cyc;
        int dn;
        int exp_lines;
        int exp_cyc;
        logic last_done;
        model_clear(exp_lines, exp_cyc);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        cyc = 0; dn = 0; last_done = 1'b0;
        while (clear_busy && cyc < 3000) begin
            cyc++;
            if (clear_done) dn++;
            last_done = clear_done;
            if (noise && (cyc == 5 || cyc == 12)) begin
                board_we    = 1'b1;
                board_wx    = 4'd2;
                board_wy    = 5'd3;
                board_wdata = ~m[3][2];
                clear_start = 1'b1;
            end else begin
                board_we    = 1'b0;
                clear_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        board_we    = 1'b0;
        clear_start = 1'b0;
        check({name, "_busy_cycles"}, cyc, exp_cyc);
        check({name, "_done_pulses"}, dn, 1);
        check({name, "_done_last"}, int'(last_done), 1);
        check({name, "_lines"}, int'(lines_cleared), exp_lines);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_idle_after"}, int'(clear_busy), 0);
        check({name, "_lines_hold"}, int'(lines_cleared), exp_lines);
        check_board(name);
    endtask

    initial begin
        logic v;
        int dummy_l;
        int dummy_c;

        resetn      = 1'b0;
        board_rx    = '0;
        board_ry    = '0;
        board_we    = 1'b0;
        board_wx    = '0;
        board_wy    = '0;
        board_wdata = 1'b0;
        clear_start = 1'b0;
`ifdef BOARD_VGA_PORT_EN
        vga_rx = '0;
        vga_ry = '0;
`endif
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(clear_busy), 0);
        check("reset_done", int'(clear_done), 0);
        check("reset_lines", int'(lines_cleared), 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_board("reset_board");

        tbl[0] = '{1'b1, 4'd3,  5'd7,  1'b1, 4'd3,  5'd7,  1'b0, 1'b1};
        tbl[1] = '{1'b0, 4'd0,  5'd0,  1'b0, 4'd3,  5'd8,  1'b0, 1'b0};
        tbl[2] = '{1'b1, 4'd12, 5'd7,  1'b1, 4'd3,  5'd7,  1'b1, 1'b1};
        tbl[3] = '{1'b1, 4'd3,  5'd7,  1'b0, 4'd3,  5'd7,  1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'd0,  5'd0,  1'b0, 4'd10, 5'd0,  1'b1, 1'b1};
        tbl[5] = '{1'b0, 4'd0,  5'd0,  1'b0, 4'd0,  5'd20, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 4'd9,  5'd19, 1'b1, 4'd9,  5'd19, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 4'd0,  5'd25, 1'b1, 4'd0,  5'd25, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 4'd15, 5'd31, 1'b1, 4'd15, 5'd31, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 4'd0,  5'd0,  1'b1, 4'd0,  5'd0,  1'b0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            board_we    = tbl[i].we;
            board_wx    = tbl[i].wx;
            board_wy    = tbl[i].wy;
            board_wdata = tbl[i].wd;
            board_rx    = tbl[i].rx;
            board_ry    = tbl[i].ry;
            #1;
            check($sformatf("tbl%0d_same_cycle", i), int'(board_rdata), int'(tbl[i].e_now));
            @(posedge clk); #1;
            check($sformatf("tbl%0d_next_cycle", i), int'(board_rdata), int'(tbl[i].e_next));
            board_we = 1'b0;
            if (tbl[i].we) model_write(int'(tbl[i].wx), int'(tbl[i].wy), tbl[i].wd);
        end
        check_board("tbl_board");

        // Reset asserted while the engine is collapsing rows.
        do_reset();
        for (int x = 0; x < 10; x++) wr(x, 19, 1'b1);
        wr(4, 18, 1'b1);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        model_zero();
        check("midshift_reset_busy", int'(clear_busy), 0);
        check("midshift_reset_done", int'(clear_done), 0);
        check("midshift_reset_lines", int'(lines_cleared), 0);
        check_board("midshift_reset_board");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_busy", int'(clear_busy), 0);

        // No full row: 21 busy cycles, board untouched.
        for (int x = 0; x < 9; x++) wr(x, 19, 1'b1);
        do_clear("no_clear", 1'b0);

        // Single clear with a lone cell above.
        do_reset();
        for (int x = 0; x < 10; x++) wr(x, 19, 1'b1);
        wr(4, 18, 1'b1);
        do_clear("single", 1'b0);
        read_cell(4, 19, v);
        check("single_4_19", int'(v), 1);

        // Four stacked rows, with ignored writes and clear_start while busy.
        do_reset();
        for (int y = 16; y < 20; y++)
            for (int x = 0; x < 10; x++) wr(x, y, 1'b1);
        wr(0, 15, 1'b1);
        do_clear("stacked", 1'b1);
        read_cell(0, 19, v);
        check("stacked_0_19", int'(v), 1);

        // Eight full rows: count saturates at 7.
        do_reset();
        for (int y = 12; y < 20; y++)
            for (int x = 0; x < 10; x++) wr(x, y, 1'b1);
        do_clear("saturate", 1'b0);

        // Full row at index 0 exercises the single-cycle top-row clear.
        do_reset();
        for (int x = 0; x < 10; x++) wr(x, 0, 1'b1);
        wr(5, 1, 1'b1);
        do_clear("top_row", 1'b0);

        // Randomized boards against the model.
        for (int it = 0; it < 6; it++) begin
            bit [9:0] tgt [20];
            for (int y = 0; y < 20; y++) begin
                if ($urandom_range(0, 2) == 0) tgt[y] = 10'h3FF;
                else tgt[y] = 10'($urandom) & 10'($urandom | 32'h1);
            end
            for (int y = 0; y < 20; y++)
                for (int x = 0; x < 10; x++)
                    if (m[y][x] != tgt[y][x]) wr(x, y, tgt[y][x]);
            do_clear($sformatf("rand%0d", it), it[0]);
        end

        // Clear of an already-empty board is still a complete 21-cycle pass.
        do_reset();
        do_clear("empty", 1'b0);
        model_clear(dummy_l, dummy_c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
